// File: rtl/video_timing_gen.sv
// Raster timing generator: blanking, sync, data-enable, pixel coordinates and a
// line-repeating frame-buffer address, advancing one position per pixel clock-enable.
module video_timing_gen #(
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int ADDR_BITS  = 19,
    parameter int ADDR_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 en,
    output logic                 h_blank,
    output logic                 v_blank,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 de,
    output logic [H_BITS-1:0]    x,
    output logic [V_BITS-1:0]    y,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_BITS-1:0] H_LAST       = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_ACT_END    = H_BITS'(H_ACTIVE);
    localparam logic [H_BITS-1:0] H_SYNC_START = H_BITS'(H_ACTIVE + H_FP);
    localparam logic [H_BITS-1:0] H_SYNC_END   = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_BITS-1:0] V_LAST       = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_ACT_END    = V_BITS'(V_ACTIVE);
    localparam logic [V_BITS-1:0] V_ACT_LAST   = V_BITS'(V_ACTIVE - 1);
    localparam logic [V_BITS-1:0] V_SYNC_START = V_BITS'(V_ACTIVE + V_FP);
    localparam logic [V_BITS-1:0] V_SYNC_END   = V_BITS'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_BITS-1:0] REP_MASK     = V_BITS'((1 << ADDR_SHIFT) - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [H_BITS-1:0]    hc_q, hc_d;
    logic [V_BITS-1:0]    vc_q, vc_d;
    logic [ADDR_BITS-1:0] line_base_q, line_base_d;

    logic                 h_blank_q, h_blank_d, v_blank_q, v_blank_d;
    logic                 h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic                 de_q, de_d;
    logic [H_BITS-1:0]    x_q, x_d;
    logic [V_BITS-1:0]    y_q, y_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 line_start_q, line_start_d;
    logic                 frame_start_q, frame_start_d;
    logic                 running_q, running_d;

    logic                 line_wrap, frame_wrap;
    logic                 advance, go_idle, present;
    logic                 hb, vb;

    always_comb begin
        state_d       = state_q;
        hc_d          = hc_q;
        vc_d          = vc_q;
        line_base_d   = line_base_q;
        h_blank_d     = h_blank_q;
        v_blank_d     = v_blank_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        running_d     = running_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        advance       = 1'b0;
        go_idle       = 1'b0;
        present       = 1'b0;
        hb            = 1'b1;
        vb            = 1'b1;

        line_wrap  = (hc_q == H_LAST);
        frame_wrap = line_wrap && (vc_q == V_LAST);

        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_d = ST_RUN;
                        present = 1'b1;
                    end
                end
                ST_RUN: begin
                    advance = 1'b1;
                    if (!en) begin
                        state_d = frame_wrap ? ST_IDLE : ST_DRAIN;
                        go_idle = frame_wrap;
                    end
                    present = !go_idle;
                end
                ST_DRAIN: begin
                    advance = 1'b1;
                    if (frame_wrap) begin
                        state_d = en ? ST_RUN : ST_IDLE;
                        go_idle = !en;
                    end
                    present = !go_idle;
                end
                default: begin
                    state_d = ST_IDLE;
                    go_idle = 1'b1;
                end
            endcase
        end

        // Line base steps at the end of a line: cleared after the last active
        // line, bumped after the last repeat of each source line.
        if (advance) begin
            hc_d = line_wrap ? '0 : hc_q + H_BITS'(1);
            if (line_wrap) begin
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + V_BITS'(1);
                if (vc_q == V_ACT_LAST) begin
                    line_base_d = '0;
                end else if ((vc_q < V_ACT_END) && ((vc_q & REP_MASK) == REP_MASK)) begin
                    line_base_d = line_base_q + ADDR_BITS'(H_ACTIVE);
                end
            end
        end

        if (go_idle) begin
            hc_d        = '0;
            vc_d        = '0;
            line_base_d = '0;
            h_blank_d   = 1'b1;
            v_blank_d   = 1'b1;
            h_sync_d    = ~H_SYNC_POL;
            v_sync_d    = ~V_SYNC_POL;
            de_d        = 1'b0;
            x_d         = '0;
            y_d         = '0;
            addr_d      = '0;
            running_d   = 1'b0;
        end

        if (present) begin
            hb            = (hc_d >= H_ACT_END);
            vb            = (vc_d >= V_ACT_END);
            h_blank_d     = hb;
            v_blank_d     = vb;
            de_d          = !hb && !vb;
            h_sync_d      = ((hc_d >= H_SYNC_START) && (hc_d < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_d      = ((vc_d >= V_SYNC_START) && (vc_d < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            x_d           = hc_d;
            y_d           = vc_d;
            addr_d        = (!hb && !vb) ? line_base_d + ADDR_BITS'(hc_d) : '0;
            line_start_d  = (hc_d == '0);
            frame_start_d = (hc_d == '0) && (vc_d == '0);
            running_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hc_q          <= '0;
            vc_q          <= '0;
            line_base_q   <= '0;
            h_blank_q     <= 1'b1;
            v_blank_q     <= 1'b1;
            h_sync_q      <= ~H_SYNC_POL;
            v_sync_q      <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            line_base_q   <= line_base_d;
            h_blank_q     <= h_blank_d;
            v_blank_q     <= v_blank_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign h_blank     = h_blank_q;
    assign v_blank     = v_blank_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign addr        = addr_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on an 8x6 raster (H 4/1/2/1, V 3/1/1/1, line repeat x2);
// a second instance with inverted h_sync polarity shares every input.
module tb_video_timing_gen;

    localparam int HB = 4;
    localparam int VB = 4;
    localparam int AB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          en;

    logic          h_blank, v_blank, h_sync, v_sync, de;
    logic [HB-1:0] x;
    logic [VB-1:0] y;
    logic [AB-1:0] addr;
    logic          line_start, frame_start, running;

    logic          h_blank_p, v_blank_p, h_sync_p, v_sync_p, de_p;
    logic [HB-1:0] x_p;
    logic [VB-1:0] y_p;
    logic [AB-1:0] addr_p;
    logic          line_start_p, frame_start_p, running_p;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int lastFs   = -1;
    int fsCount  = 0;

    video_timing_gen #(
        .H_BITS(HB), .V_BITS(VB),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .ADDR_BITS(AB), .ADDR_SHIFT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .en(en),
        .h_blank(h_blank), .v_blank(v_blank), .h_sync(h_sync), .v_sync(v_sync),
        .de(de), .x(x), .y(y), .addr(addr),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    video_timing_gen #(
        .H_BITS(HB), .V_BITS(VB),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
        .ADDR_BITS(AB), .ADDR_SHIFT(1)
    ) dut_pol (
        .clk(clk), .rst_n(rst_n), .ce(ce), .en(en),
        .h_blank(h_blank_p), .v_blank(v_blank_p), .h_sync(h_sync_p), .v_sync(v_sync_p),
        .de(de_p), .x(x_p), .y(y_p), .addr(addr_p),
        .line_start(line_start_p), .frame_start(frame_start_p), .running(running_p)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
    task automatic applyStimulus(input logic ceVal, input logic enVal);
        ce = ceVal;
        en = enVal;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_h_blank"}, 32'(h_blank), 1);
        checkOutput({tag, "_v_blank"}, 32'(v_blank), 1);
        checkOutput({tag, "_de"}, 32'(de), 0);
        checkOutput({tag, "_h_sync"}, 32'(h_sync), 1);
        checkOutput({tag, "_v_sync"}, 32'(v_sync), 1);
        checkOutput({tag, "_x"}, 32'(x), 0);
        checkOutput({tag, "_y"}, 32'(y), 0);
        checkOutput({tag, "_addr"}, 32'(addr), 0);
        checkOutput({tag, "_line_start"}, 32'(line_start), 0);
        checkOutput({tag, "_frame_start"}, 32'(frame_start), 0);
        checkOutput({tag, "_running"}, 32'(running), 0);
        checkOutput({tag, "_pol_h_sync"}, 32'(h_sync_p), 0);
        checkOutput({tag, "_pol_v_sync"}, 32'(v_sync_p), 1);
    endtask

    // Hand-derived raster: active x 0..3, h_sync at x 5..6, active y 0..2, v_sync on line 4;
    // lines 0 and 1 both read source line 0 (addr 0..3), line 2 reads source line 1 (addr 4..7).
    task automatic checkPixel(input string tag, input int ex, input int ey, input logic strobeCycle);
        logic expHb, expVb, expDe, expHsAct, expVsAct, expLs, expFs;
        int   expAddr;
        expHb    = (ex >= 4);
        expVb    = (ey >= 3);
        expDe    = !expHb && !expVb;
        expHsAct = (ex == 5) || (ex == 6);
        expVsAct = (ey == 4);
        expAddr  = expDe ? (((ey == 2) ? 4 : 0) + ex) : 0;
        expLs    = strobeCycle && (ex == 0);
        expFs    = expLs && (ey == 0);
        checkOutput($sformatf("%s_x@%0d,%0d", tag, ex, ey), 32'(x), 32'(ex));
        checkOutput($sformatf("%s_y@%0d,%0d", tag, ex, ey), 32'(y), 32'(ey));
        checkOutput($sformatf("%s_h_blank@%0d,%0d", tag, ex, ey), 32'(h_blank), 32'(expHb));
        checkOutput($sformatf("%s_v_blank@%0d,%0d", tag, ex, ey), 32'(v_blank), 32'(expVb));
        checkOutput($sformatf("%s_de@%0d,%0d", tag, ex, ey), 32'(de), 32'(expDe));
        checkOutput($sformatf("%s_h_sync@%0d,%0d", tag, ex, ey), 32'(h_sync), 32'(!expHsAct));
        checkOutput($sformatf("%s_v_sync@%0d,%0d", tag, ex, ey), 32'(v_sync), 32'(!expVsAct));
        checkOutput($sformatf("%s_addr@%0d,%0d", tag, ex, ey), 32'(addr), 32'(expAddr));
        checkOutput($sformatf("%s_line_start@%0d,%0d", tag, ex, ey), 32'(line_start), 32'(expLs));
        checkOutput($sformatf("%s_frame_start@%0d,%0d", tag, ex, ey), 32'(frame_start), 32'(expFs));
        checkOutput($sformatf("%s_running@%0d,%0d", tag, ex, ey), 32'(running), 1);
        checkOutput($sformatf("%s_pol_h_sync@%0d,%0d", tag, ex, ey), 32'(h_sync_p), 32'(expHsAct));
        checkOutput($sformatf("%s_pol_v_sync@%0d,%0d", tag, ex, ey), 32'(v_sync_p), 32'(!expVsAct));
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("reset");

        // Continuous run: two full frames plus the first pixel of the third.
        rst_n = 1'b1;
        for (int k = 0; k < 97; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkPixel("run", k % 8, (k / 8) % 6, 1'b1);
        end

        // Drop en after (2,1): frame drains to (7,5), then idles.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkPixel("pre_drain", k % 8, k / 8, 1'b1);
        end
        for (int k = 11; k < 48; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkPixel("drain", k % 8, k / 8, 1'b1);
        end
        applyStimulus(1'b1, 1'b0);
        checkIdle("drain_end");
        applyStimulus(1'b1, 1'b0);
        checkIdle("idle_hold");

        // en drops at (2,1) and returns mid-drain: next frame follows with no gap.
        for (int k = 0; k < 48; k++) begin
            applyStimulus(1'b1, (k >= 11 && k < 29) ? 1'b0 : 1'b1);
            checkPixel("redrain", k % 8, k / 8, 1'b1);
        end
        for (int k = 0; k < 48; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkPixel("nogap", k % 8, k / 8, 1'b1);
        end

        // en falls on the very ce that wraps the frame: straight to idle.
        applyStimulus(1'b1, 1'b0);
        checkIdle("wrap_stop");

        // ce on every third clk: outputs hold between pulses, strobes last one clk.
        cycle = 0;
        for (int p = 0; p < 49; p++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(c == 0, 1'b1);
                checkPixel("ce3", p % 8, (p / 8) % 6, c == 0);
                if (frame_start === 1'b1) begin
                    if (lastFs >= 0) checkOutput("ce3_frame_period", 32'(cycle - lastFs), 144);
                    lastFs = cycle;
                    fsCount++;
                end
            end
        end
        checkOutput("ce3_frame_starts", 32'(fsCount), 2);

        // Asynchronous reset at (3,2), then restart from (0,0).
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkPixel("pre_rst", k % 8, k / 8, 1'b1);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkIdle("async_rst");
        applyStimulus(1'b1, 1'b1);
        checkIdle("rst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkPixel("after_rst", k % 8, k / 8, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the display path. It produces blanking, sync, data-enable, pixel coordinates and a linear frame-buffer read address from one clock, gated by a pixel clock-enable. It has separate horizontal and vertical geometry, programmable sync polarity, a line-repeat address mode and a run/stop controller with a clean frame-boundary stop. It drives the pixel fetch and the video output stage.

## Interface
- H_BITS, 10: width of horizontal counter and `x`.
- V_BITS, 10: width of vertical counter and `y`.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640/16/96/48: horizontal region lengths in pixels; each ≥1; sum H_TOTAL ≤ 2^H_BITS.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480/10/2/33: vertical region lengths in lines; each ≥1; sum V_TOTAL ≤ 2^V_BITS.
- H_SYNC_POL / V_SYNC_POL, 0/0: asserted level of `h_sync` / `v_sync` (0 = active-low).
- ADDR_BITS, 19: width of `addr`.
- ADDR_SHIFT, 0: each source line is repeated 2^ADDR_SHIFT times.
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- ce, in, 1: pixel clock-enable; the generator advances only on cycles with ce=1.
- en, in, 1: run request.
- h_blank / v_blank, out, 1: outside horizontal / vertical active region.
- h_sync / v_sync, out, 1: sync, at the polarity set by the parameters.
- de, out, 1: ~h_blank & ~v_blank.
- x, out, H_BITS: horizontal position.
- y, out, V_BITS: vertical position.
- addr, out, ADDR_BITS: frame-buffer address; 0 whenever de=0.
- line_start, out, 1: one-clk strobe when x=0.
- frame_start, out, 1: one-clk strobe when x=0 and y=0.
- running, out, 1: high in RUN or DRAIN.

## Operation
- Position counters:
  - hc runs 0..H_TOTAL-1. Active region is 0..H_ACTIVE-1, then FP, SYNC, BP.
  - vc increments when hc wraps, and wraps at V_TOTAL-1. Vertical regions are laid out the same way.
  - v_sync changes together with the hc wrap, never mid-line.
- State machine:
  - IDLE: counters held at (0,0); outputs idle. Goes to RUN on a ce cycle with en=1.
  - RUN: advances one position per ce. If en=0 at any ce, goes to DRAIN.
  - DRAIN: keeps running to the end of the frame, ignoring en. On the ce that would wrap to (0,0), goes to IDLE if en=0, otherwise back to RUN (seamless, no gap frame).
- Outputs are registered and updated only on ce cycles. They present the position computed by that ce.
- Idle output values (also the reset values):
  - h_blank=v_blank=1, de=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - x=y=0, addr=0.
  - line_start=frame_start=0, running=0.
- Address generation:
  - line_base register; pixel address = line_base + x, modulo 2^ADDR_BITS.
  - After the last active line of each frame, line_base is cleared to 0.
  - After each active line where y[ADDR_SHIFT-1:0] is all ones, line_base += H_ACTIVE. With ADDR_SHIFT=0 this happens after every line.
- Strobes are high only in the clk cycle right after the ce that presents x=0 (and y=0 for frame_start). They are low in every other cycle, even while ce is low.
- Reset mid-frame: all state and outputs go to idle values immediately (asynchronous). The state machine returns to IDLE and the next run starts at (0,0).
- Simultaneous events:
  - en falling on the ce that wraps the frame: go to IDLE directly.
  - en rising in DRAIN: no effect until the frame boundary.

## Timing
- Latency: position p appears on the outputs one clk after the ce that advances to p.
- Outputs hold their values between ce pulses.
- First output after leaving IDLE is (0,0), with frame_start=1 and line_start=1.
- Frame period: H_TOTAL·V_TOTAL ce pulses. h_sync is asserted for exactly H_SYNC pulses per line. v_sync is asserted for exactly V_SYNC lines.
- ce=1 continuously gives one pixel per clk. No combinational path from inputs to outputs.

## Test plan
Geometry for all scenarios unless noted: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), ADDR_SHIFT=1, ce=1.
- Reset release, en=1 → first output (0,0) with frame_start=1. h_sync active at x=5,6. Line repeats every 8 clks. y wraps after 48 clks.
- Same run → addr sequence: line 0 = 0,1,2,3; line 1 = 0,1,2,3; line 2 = 4,5,6,7. addr=0 whenever de=0. Frame 2 restarts at 0.
- en dropped at pixel (2,1) → output continues through (7,5), then returns to idle values with running=0. en re-asserted in DRAIN → frame continues, no idle gap.
- ce=1 every 3rd clk → outputs change only after ce. Strobes last 1 clk. Frame period is 144 clks.
- rst_n low mid-line at (3,2) → all outputs idle asynchronously. After release, restart from (0,0).
- H_SYNC_POL=1, V_SYNC_POL=0 → h_sync idles 0 and pulses 1; v_sync idles 1 and pulses 0 during line 4.
